// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: NOP encoding and fetch FSM states.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a new
// instruction, otherwise the contents hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // Next-state selection; flush wins over load.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  // Register with synchronous active-low reset to a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, run/halt FSM, fetch counter and the IF/ID register.
//
//   state  | meaning
//   RUN    | fetching; redirect > halt > stall > advance
//   HALTED | syscall seen; PC and IF/ID frozen until reset
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;
  logic             ifid_load;
  logic             ifid_flush;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state, PC, counter and IF/ID control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d       = redirect_pc & ~32'h3;
          ifid_flush = 1'b1;
        end else if (halt) begin
          ifid_flush = 1'b1;
          state_d    = HALTED;
        end else if (!stall) begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, PC and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .instr_in (imem_rdata),
    .pc4_in   (pc_plus4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

  // Upper PC bits alias into the instruction memory.
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc        = pc_q;
  assign halted    = (state_q == HALTED);
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-edge vectors plus a
// hand-written halted-freeze sequence.
module tb_fetch_stage;

  localparam int IMEM_AW = 10;
  localparam int CNT_W   = 32;

  logic               clk;
  logic               rst_n;
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               halt;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        pc;
  logic [31:0]        if_id_instr;
  logic [31:0]        if_id_pc4;
  logic               if_id_valid;
  logic               halted;
  logic [CNT_W-1:0]   fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (IMEM_AW),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_cnt   (fetch_cnt)
  );

  // Instruction memory model: imem[i] = i + 1.
  assign imem_rdata = 32'(imem_addr) + 32'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic        halt;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic rd, logic h, logic [31:0] rpc,
                              logic [31:0] epc, logic [31:0] ei, logic [31:0] ep4,
                              logic ev, logic eh, logic [31:0] ec);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redirect = rd; v.halt = h; v.rpc = rpc;
    v.e_pc = epc; v.e_instr = ei; v.e_pc4 = ep4; v.e_valid = ev;
    v.e_halted = eh; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_and_check(input vec_t v, input int idx);
    logic [31:0] exp_addr;
    rst_n       = v.rst_n;
    stall       = v.stall;
    redirect    = v.redirect;
    halt        = v.halt;
    redirect_pc = v.rpc;
    @(posedge clk);
    #1;
    exp_addr = {22'h0, v.e_pc[IMEM_AW+1:2]};
    check($sformatf("v%0d pc", idx),        pc,                 v.e_pc);
    check($sformatf("v%0d imem_addr", idx), 32'(imem_addr),     exp_addr);
    check($sformatf("v%0d instr", idx),     if_id_instr,        v.e_instr);
    check($sformatf("v%0d pc4", idx),       if_id_pc4,          v.e_pc4);
    check($sformatf("v%0d valid", idx),     32'(if_id_valid),   32'(v.e_valid));
    check($sformatf("v%0d halted", idx),    32'(halted),        32'(v.e_halted));
    check($sformatf("v%0d fetch_cnt", idx), fetch_cnt,          v.e_cnt);
  endtask

  int split_idx;

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'h0;

    //               rst stl rd  hlt rpc           pc            instr         pc4           v  h  cnt
    // free run after reset
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h4,        32'h1,        32'h4,        1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h8,        32'h2,        32'h8,        1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'hC,        32'h3,        32'hC,        1, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h10,       32'h4,        32'h10,       1, 0, 4));
    // stall two cycles at pc=8
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h4,        32'h1,        32'h4,        1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h8,        32'h2,        32'h8,        1, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h8,        32'h2,        32'h8,        1, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h8,        32'h2,        32'h8,        1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'hC,        32'h3,        32'hC,        1, 0, 3));
    // redirect to 0x43 under stall -> pc 0x40, one bubble, then imem[0x10]
    vecs.push_back(mk(1, 1, 1, 0, 32'h43,       32'h40,       32'h0,        32'h0,        0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h44,       32'h11,       32'h44,       1, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h48,       32'h12,       32'h48,       1, 0, 5));
    // move to pc=0x20 then halt
    vecs.push_back(mk(1, 0, 1, 0, 32'h20,       32'h20,       32'h0,        32'h0,        0, 0, 5));
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,        32'h20,       32'h0,        32'h0,        0, 1, 5));
    split_idx = vecs.size();
    // halt and redirect on the same edge: redirect wins
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h81,       32'h80,       32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h84,       32'h21,       32'h84,       1, 0, 1));
    // PC wrap and reset during stall
    vecs.push_back(mk(1, 0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,      32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        32'h400,      32'h0,        1, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h0,        32'h400,      32'h0,        1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h4,        32'h1,        32'h4,        1, 0, 1));

    @(negedge clk);
    for (int i = 0; i < split_idx; i++) apply_and_check(vecs[i], i);

    // Halted: ten cycles of toggling inputs must not move anything.
    for (int k = 0; k < 10; k++) begin
      rst_n       = 1'b1;
      redirect    = k[0];
      stall       = 1'($urandom_range(0, 1));
      halt        = 1'($urandom_range(0, 1));
      redirect_pc = $urandom;
      @(posedge clk);
      #1;
      check($sformatf("halt%0d pc", k),     pc,               32'h20);
      check($sformatf("halt%0d halted", k), 32'(halted),      32'd1);
      check($sformatf("halt%0d valid", k),  32'(if_id_valid), 32'd0);
      check($sformatf("halt%0d instr", k),  if_id_instr,      32'h0);
      check($sformatf("halt%0d cnt", k),    fetch_cnt,        32'd5);
    end

    for (int i = split_idx; i < vecs.size(); i++) apply_and_check(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
